// File: rtl/core_pkg.sv
// core_pkg: types and constants shared by the RV32I instruction-fetch front end.
package core_pkg;

    // Fetch FSM states.
    typedef enum logic [0:0] {
        IF_FETCH = 1'b0,
        IF_DRAIN = 1'b1
    } if_state_t;

    // Bytes per instruction word; every sequential fetch advances the PC by this.
    localparam int unsigned INSTR_BYTES = 4;

    // Default first fetch address after reset.
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_fifo.sv
// if_fifo: synchronous prefetch buffer. A clear wins over both push and pop.
// The head reads as zero while the buffer is empty.
module if_fifo
    import core_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       clear,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [WIDTH-1:0]           head
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             pop_eff;

    assign pop_eff = pop && !clear && (count_q != '0);

    // Pointer and occupancy update; clear resets everything to empty.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop_eff) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop_eff})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents only matter while counted as occupied, so no reset.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign count = count_q;
    assign head  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

    // The credit check upstream must make a push into a full buffer impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !clear && !pop_eff && (count_q == FULL)));

endmodule

// File: rtl/if_prefetch.sv
// if_prefetch: credit-limited instruction prefetch front end between the
// instruction-memory port and decode. Sequential word fetches run ahead of
// consumption; a redirect flushes the buffer and discards in-flight responses.
// Optional feature macro: IF_PREFETCH_PERF_EN adds saturating counters
// perf_fetched (pops) and perf_dropped (responses discarded by a redirect).
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// IF_FETCH | issue requests while buffer + in-flight < DEPTH; push responses
// IF_DRAIN | no requests; swallow stale responses until none are in flight
module if_prefetch
    import core_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc
`ifdef IF_PREFETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_dropped
`endif
);

    localparam int unsigned     CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0]     DEPTH_C = (CW + 1)'(DEPTH);
    localparam logic [XLEN-1:0] STEP    = XLEN'(INSTR_BYTES);

    if_state_t       state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic            run_q;

    logic [CW-1:0]   fifo_count;
    logic [2*XLEN-1:0] fifo_head;
    logic [CW:0]     credit_used;
    logic [XLEN-1:0] redir_pc;
    logic            req_fire;
    logic            push;
    logic            pop;

    // Low address bits of a redirect target are ignored: fetches are word aligned.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign redir_pc = {redirect_pc[XLEN-1:2], 2'b00};

    // run_q holds requests off while reset is asserted, keeping the request
    // strobe a pure register function.
    assign credit_used    = {1'b0, fifo_count} + {1'b0, outstanding_q};
    assign imem_req_valid = run_q && (state_q == IF_FETCH) && (credit_used < DEPTH_C);
    assign imem_addr      = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign instr_valid = (fifo_count != '0);
    assign pop         = instr_valid && instr_ready;
    assign push        = (state_q == IF_FETCH) && imem_rsp_valid && !redirect_valid;
    assign {instr_pc, instr} = fifo_head;

    // Next-state logic: credit accounting, PC advance, redirect and drain handling.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q;

        if (req_fire && !imem_rsp_valid) begin
            outstanding_d = outstanding_q + 1'b1;
        end else if (!req_fire && imem_rsp_valid) begin
            outstanding_d = outstanding_q - 1'b1;
        end

        if (req_fire) begin
            fetch_pc_d = fetch_pc_q + STEP;
        end

        if (redirect_valid) begin
            fetch_pc_d = redir_pc;
            rsp_pc_d   = redir_pc;
            state_d    = (outstanding_d != '0) ? IF_DRAIN : IF_FETCH;
        end else begin
            case (state_q)
                IF_FETCH: begin
                    if (imem_rsp_valid) begin
                        rsp_pc_d = rsp_pc_q + STEP;
                    end
                end
                IF_DRAIN: begin
                    if (outstanding_d == '0) begin
                        state_d = IF_FETCH;
                    end
                end
                default: state_d = IF_FETCH;
            endcase
        end
    end

    // State, PC and credit registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IF_FETCH;
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            run_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            run_q         <= 1'b1;
        end
    end

    if_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (push),
        .push_data ({rsp_pc_q, imem_rsp_data}),
        .pop       (pop),
        .clear     (redirect_valid),
        .count     (fifo_count),
        .head      (fifo_head)
    );

`ifdef IF_PREFETCH_PERF_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_dropped_q;
    logic        drop;

    assign drop = imem_rsp_valid && (redirect_valid || (state_q == IF_DRAIN));

    // Saturating event counters for pops and discarded responses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetched_q <= '0;
            perf_dropped_q <= '0;
        end else begin
            if (pop && (perf_fetched_q != '1)) begin
                perf_fetched_q <= perf_fetched_q + 1'b1;
            end
            if (drop && (perf_dropped_q != '1)) begin
                perf_dropped_q <= perf_dropped_q + 1'b1;
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_dropped = perf_dropped_q;
`endif

endmodule

// File: doc/if_prefetch.md
# if_prefetch

Parametrised instruction-fetch front end for the next-generation RV32I core. It replaces the direct `PC`/`Instr` coupling of the single-cycle core with a decoupled, credit-limited prefetch buffer. It sits between the instruction-memory port and decode, and issues sequential word fetches ahead of consumption. On a redirect (branch/jump) it discards the buffer and any in-flight responses.

## Interface
Parameters:
- `XLEN`, 32, address/instruction width.
- `DEPTH`, 4, prefetch buffer entries; power of two, ≥2.
- `RESET_PC`, 32'h0000_0000, first fetch address.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `redirect_valid`  in  1  flush and restart fetch at `redirect_pc`.
- `redirect_pc`  in  XLEN  new fetch address; bits [1:0] are ignored (forced to 0).
- `imem_req_valid`  out  1  fetch request.
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_addr`  out  XLEN  request address.
- `imem_rsp_valid`  in  1  response strobe; in order, never back-pressured.
- `imem_rsp_data`  in  XLEN  fetched instruction.
- `instr_valid`  out  1  buffer head is valid.
- `instr_ready`  in  1  decode consumes the head.
- `instr`  out  XLEN  head instruction.
- `instr_pc`  out  XLEN  address of the head instruction.

## Operation
- State registers:
  - `fetch_pc`: next request address.
  - `rsp_pc`: address of the next accepted response.
  - `outstanding`: in-flight count, width `$clog2(DEPTH+1)`.
  - FIFO `count`.
  - FSM state.
- FSM has two states, FETCH and DRAIN. Reset enters FETCH.
- **FETCH**
  - `imem_req_valid` = (`count` + `outstanding`) < DEPTH.
  - On request handshake: `fetch_pc` += 4 and `outstanding` += 1.
  - On response: push {`rsp_pc`, data}, then `rsp_pc` += 4 and `outstanding` −= 1.
  - A handshake and a response in the same cycle leave `outstanding` unchanged.
- **Redirect**, in any state, takes priority over all other actions:
  - FIFO cleared.
  - `fetch_pc` and `rsp_pc` ← `redirect_pc & ~3`.
  - A response arriving in the same cycle is dropped.
  - A request handshake in the same cycle still counts as outstanding.
  - Next state is DRAIN if the resulting `outstanding` > 0, else FETCH.
- **DRAIN**
  - `imem_req_valid` = 0.
  - Each response is dropped and decrements `outstanding`.
  - Moves to FETCH in the cycle after `outstanding` reaches 0.
  - A redirect while in DRAIN updates the PCs and stays in DRAIN.
- **Pop**: occurs on `instr_valid && instr_ready`. Push and pop in the same cycle leave `count` unchanged.
- **Arithmetic**: PC arithmetic is modulo 2^XLEN. 32'hFFFF_FFFC + 4 wraps to 0.
- **Credit rule**: guarantees FIFO overflow is impossible. An overflow is a design error; an assertion is required in simulation.

## Timing
- **Reset values** (asynchronous assertion):
  - `imem_req_valid` = 1 in the first cycle after release.
  - `imem_addr` = RESET_PC.
  - `instr_valid` = 0.
  - `instr` = 0, `instr_pc` = 0.
  - `outstanding` = 0, `count` = 0.
  - Reset mid-operation discards all buffered and in-flight state. Responses to pre-reset requests must not be presented by memory after reset.
- `imem_req_valid` and `imem_addr` derive from registers only. There is no combinational path from `instr_ready` or `imem_rsp_valid`.
- **Latency**:
  - Response to `instr_valid`: 1 cycle (registered FIFO).
  - Minimum redirect to first new `instr_valid`, with 1-cycle memory and nothing in flight: redirect cycle +1 for request, +1 for response, +1 for output, i.e. 3 cycles.
- `instr_valid` deasserts in the cycle after a redirect.
- **Steady state**: with 1-cycle memory and `instr_ready` held high, throughput is 1 instruction per cycle.

## Configuration
- Macro: `IF_PREFETCH_PERF_EN`.
- **Defined**: adds the outputs listed below. Both counters:
  - saturate at all-ones;
  - reset to 0;
  - have no other effect on behaviour.
- Added outputs:
  - `perf_fetched` (32): count of pops.
  - `perf_dropped` (32): responses discarded because of a redirect (same-cycle or DRAIN).
- **Undefined**: the ports and counters are absent. Functional behaviour is identical.

## Structure
- Shared package `core_pkg`:
  - FSM state enum `if_state_t` {IF_FETCH, IF_DRAIN}.
  - Constant `INSTR_BYTES` = 4.
  - Default `RESET_PC`.
- Sub-module `if_fifo`: synchronous FIFO, width 2·XLEN, depth DEPTH.
  - Signals: push, pop, clear, count, head.
  - Clear has priority over push and over pop.
- Top-level `if_prefetch` holds the FSM, PCs, `outstanding` and the credit logic.

## Test plan
- **Reset then streaming**: release reset, 1-cycle memory, `instr_ready`=1.
  - Requests go to 0x0, 0x4, 0x8, …
  - `instr_pc` = 0x0 with `instr_valid` on cycle 3.
  - Then one instruction per cycle.
- **Back-pressure**: `instr_ready`=0, DEPTH=4.
  - Exactly 4 requests are issued, then `imem_req_valid`=0.
  - Raising `instr_ready` resumes requests after the first pop.
- **Redirect with 2 in flight**: 3-cycle memory, redirect to 0x103 while `outstanding`=2.
  - Two responses are dropped (`perf_dropped`=2 when the macro is enabled).
  - First new request is 0x100.
  - `instr_pc` = 0x100.
- **Simultaneous events**:
  - A redirect coinciding with a response and a request handshake: `outstanding` = 1 in DRAIN, and the response is not presented.
  - A second redirect to 0x200 during DRAIN: fetch resumes at 0x200.
- **Wrap-around**: redirect to 0xFFFF_FFF8 gives `instr_pc` sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- **Async reset mid-stream**: assert `reset`=0 with 3 entries buffered.
  - `instr_valid` and `imem_req_valid` drop immediately.
  - After release, fetch restarts at RESET_PC.
